irq_controller: RTL and testbench

//  Interrupt controller that sequences the PC register and zero-flag flip-flop of the 8-bit core.
//  - Synchronises and edge-detects NIRQ external request lines.
//  - Arbitrates them by fixed priority, with nesting by strictly higher priority.
//  - Saves {zero flag, return PC, source id} on a hardware LIFO.
//  - Overrides the PC mux with the vector address, and with the return address on RETI.
//  - Sits between the control decoder and the PC-input mux / zero-flag FF load path.

---
 rtl/irq_controller_pkg.sv | 28 ++
 rtl/irq_controller_stack.sv | 57 +++++
 rtl/irq_controller.sv | 202 ++++++++++++++++++++
 tb/tb_irq_controller.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module : irq_controller_pkg
// Brief  : Shared types and sizing helpers for the interrupt controller.
// Rev    : 1.0
// ============================================================================
package irq_controller_pkg;

    localparam int unsigned c_pc_w_default = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VECTOR = 2'd1,
        ST_RETURN = 2'd2
    } irq_state_t;

    // A single source still needs a 1-bit id field so the stack entry stays well formed.
    function automatic int unsigned id_width(input int unsigned nirq);
        return (nirq > 1) ? $clog2(nirq) : 1;
    endfunction

    // Stack entry layout, MSB to LSB: {zflag, return PC, source id}.
    function automatic int unsigned entry_width(input int unsigned nirq, input int unsigned pc_w);
        return 1 + pc_w + id_width(nirq);
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_controller_stack.sv
`default_nettype none
// ============================================================================
// Module : irq_controller_stack
// Brief  : DEPTH x WIDTH hardware LIFO holding interrupt return context.
// Rev    : 1.0
// ============================================================================
module irq_controller_stack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned c_sp_w = $clog2(DEPTH + 1);
    localparam int unsigned c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [c_sp_w-1:0] sp_t;
    typedef logic [c_aw-1:0]   addr_t;

    logic [WIDTH-1:0] r_mem [DEPTH];
    sp_t              r_sp;
    addr_t            w_wr_addr;
    addr_t            w_rd_addr;

    assign o_full    = (r_sp == sp_t'(DEPTH));
    assign o_empty   = (r_sp == '0);
    assign w_wr_addr = addr_t'(r_sp);
    assign w_rd_addr = addr_t'(r_sp - sp_t'(1));

    // Only the pointer is reset; stale entries are unreachable once it is cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp <= '0;
        end else if (i_push && !o_full) begin
            r_sp <= r_sp + sp_t'(1);
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - sp_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push && !o_full) begin
            r_mem[w_wr_addr] <= i_din;
        end
    end

    assign o_dout = o_empty ? '0 : r_mem[w_rd_addr];

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module : irq_controller
// Brief  : Nesting fixed-priority interrupt controller driving the PC mux and
//          zero-flag reload of the 8-bit core.
// Rev    : 1.0
// ============================================================================
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int unsigned     NIRQ      = 4,
    parameter int unsigned     PC_W      = c_pc_w_default,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [PC_W-1:0] VEC_BASE  = PC_W'(10'h3F0),
    parameter int unsigned     VEC_SHIFT = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] i_irq_in,
    input  logic [NIRQ-1:0] i_irq_mask,
    input  logic            i_ei,
    input  logic            i_di,
    input  logic            i_reti,
    input  logic [PC_W-1:0] i_pc_next,
    input  logic            i_zflag,
    output logic            o_take,
    output logic [PC_W-1:0] o_irq_pc,
    output logic            o_z_restore,
    output logic            o_z_load,
    output logic [NIRQ-1:0] o_ack,
    output logic [NIRQ-1:0] o_in_service,
    output logic            o_err
);

    localparam int unsigned c_id_w    = id_width(NIRQ);
    localparam int unsigned c_entry_w = entry_width(NIRQ, PC_W);
    localparam int unsigned c_pc_lsb  = c_id_w;
    localparam int unsigned c_z_bit   = c_id_w + PC_W;

    typedef logic [c_id_w-1:0] id_t;
    typedef logic [NIRQ-1:0]   irq_t;
    typedef logic [PC_W-1:0]   pc_t;

    irq_state_t r_state;
    irq_t       r_sync1;
    irq_t       r_sync2;
    irq_t       r_sync3;
    irq_t       r_pending;
    irq_t       r_in_service;
    irq_t       r_ack;
    logic       r_gie;
    logic       r_err;
    logic       r_take;
    logic       r_z_load;
    logic       r_z_restore;
    pc_t        r_irq_pc;
    id_t        r_ret_id;

    irq_t       w_rise;
    irq_t       w_elig;
    irq_t       w_le_mask;
    irq_t       w_win_oh;
    irq_t       w_set;
    irq_t       w_isr_clr;
    id_t        w_win;
    logic       w_any;
    logic       w_prio_ok;
    logic       w_cand;
    logic       w_accept;
    logic       w_overflow;
    logic       w_do_ret;
    logic       w_ret_err;
    logic       w_full;
    logic       w_empty;
    pc_t        w_vec;
    logic [c_entry_w-1:0] w_push_entry;
    logic [c_entry_w-1:0] w_top;

    // Two synchroniser stages, the third flop only remembers the previous level.
    assign w_rise = r_sync2 & ~r_sync3;
    assign w_elig = r_pending & i_irq_mask;
    assign w_any  = |w_elig;

    always_comb begin
        w_win = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = id_t'(i);
            end
        end
    end

    // Bits at or above the winner's priority; any of them in service blocks nesting.
    always_comb begin
        w_le_mask = '0;
        for (int i = 0; i < NIRQ; i++) begin
            w_le_mask[i] = (id_t'(i) <= w_win);
        end
    end

    assign w_prio_ok  = ~|(r_in_service & w_le_mask);
    assign w_cand     = (r_state == ST_IDLE) && r_gie && w_any && w_prio_ok && !i_reti;
    assign w_accept   = w_cand && !w_full;
    assign w_overflow = w_cand && w_full;
    assign w_do_ret   = (r_state == ST_IDLE) && i_reti && !w_empty;
    assign w_ret_err  = i_reti && ((r_state != ST_IDLE) || w_empty);

    assign w_win_oh  = irq_t'(1) << w_win;
    assign w_set     = w_accept ? w_win_oh : '0;
    assign w_isr_clr = (r_state == ST_RETURN) ? (irq_t'(1) << r_ret_id) : '0;
    assign w_vec     = VEC_BASE + (pc_t'(w_win) << VEC_SHIFT);

    assign w_push_entry = {i_zflag, i_pc_next, w_win};

    irq_controller_stack #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_accept),
        .i_pop   (w_do_ret),
        .i_din   (w_push_entry),
        .o_dout  (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_sync1      <= '0;
            r_sync2      <= '0;
            r_sync3      <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_ack        <= '0;
            r_gie        <= 1'b0;
            r_err        <= 1'b0;
            r_take       <= 1'b0;
            r_z_load     <= 1'b0;
            r_z_restore  <= 1'b0;
            r_irq_pc     <= '0;
            r_ret_id     <= '0;
        end else begin
            r_sync1 <= i_irq_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;

            // A fresh edge on the winner in the accept cycle stays pending.
            r_pending    <= (r_pending & ~w_set) | w_rise;
            r_in_service <= (r_in_service | w_set) & ~w_isr_clr;

            if (i_di) begin
                r_gie <= 1'b0;
            end else if (i_ei) begin
                r_gie <= 1'b1;
            end

            if (w_overflow || w_ret_err) begin
                r_err <= 1'b1;
            end

            r_take      <= 1'b0;
            r_irq_pc    <= '0;
            r_ack       <= '0;
            r_z_load    <= 1'b0;
            r_z_restore <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_do_ret) begin
                        r_state     <= ST_RETURN;
                        r_take      <= 1'b1;
                        r_irq_pc    <= w_top[c_pc_lsb +: PC_W];
                        r_z_load    <= 1'b1;
                        r_z_restore <= w_top[c_z_bit];
                        r_ret_id    <= w_top[c_id_w-1:0];
                    end else if (w_accept) begin
                        r_state  <= ST_VECTOR;
                        r_take   <= 1'b1;
                        r_irq_pc <= w_vec;
                        r_ack    <= w_win_oh;
                    end
                end
                ST_VECTOR: r_state <= ST_IDLE;
                ST_RETURN: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_take       = r_take;
    assign o_irq_pc     = r_irq_pc;
    assign o_z_restore  = r_z_restore;
    assign o_z_load     = r_z_load;
    assign o_ack        = r_ack;
    assign o_in_service = r_in_service;
    assign o_err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_irq_controller
// Brief  : Scoreboard bench for irq_controller against a queue-based model.
// Rev    : 1.0
// ============================================================================
module tb_irq_controller;

    localparam int        NIRQ      = 8;
    localparam int        PC_W      = 10;
    localparam int        DEPTH     = 4;
    localparam int        VEC_SHIFT = 1;
    localparam logic [9:0] VEC_BASE = 10'h3F0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] i_irq_in = '0;
    logic [7:0] i_irq_mask = 8'hFF;
    logic       i_ei = 1'b0;
    logic       i_di = 1'b0;
    logic       i_reti = 1'b0;
    logic [9:0] i_pc_next = '0;
    logic       i_zflag = 1'b0;
    logic       o_take;
    logic [9:0] o_irq_pc;
    logic       o_z_restore;
    logic       o_z_load;
    logic [7:0] o_ack;
    logic [7:0] o_in_service;
    logic       o_err;

    always #5 clk = ~clk;

    irq_controller #(
        .NIRQ      (NIRQ),
        .PC_W      (PC_W),
        .DEPTH     (DEPTH),
        .VEC_BASE  (VEC_BASE),
        .VEC_SHIFT (VEC_SHIFT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_irq_in     (i_irq_in),
        .i_irq_mask   (i_irq_mask),
        .i_ei         (i_ei),
        .i_di         (i_di),
        .i_reti       (i_reti),
        .i_pc_next    (i_pc_next),
        .i_zflag      (i_zflag),
        .o_take       (o_take),
        .o_irq_pc     (o_irq_pc),
        .o_z_restore  (o_z_restore),
        .o_z_load     (o_z_load),
        .o_ack        (o_ack),
        .o_in_service (o_in_service),
        .o_err        (o_err)
    );

    typedef struct {
        logic [9:0] pc;
        logic [7:0] ack;
        logic       zl;
        logic       zr;
        int         cyc;
    } exp_t;

    typedef struct {
        logic       z;
        logic [9:0] pc;
        int         id;
    } ent_t;

    exp_t       exp_q[$];
    ent_t       m_stk[$];
    logic [7:0] samp[$];
    logic [7:0] m_pend = '0;
    logic [7:0] m_isr = '0;
    logic       m_gie = 1'b0;
    logic       m_err = 1'b0;
    int         m_phase = 0;
    int         m_retid = 0;
    int         m_cyc = 0;
    int         n_total = 0;
    int         n_bad = 0;

    function automatic void chk(input string name, input logic ok,
                                input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Reference model: 0 = idle, 1 = vectoring, 2 = returning.
    always @(posedge clk or posedge reset) begin : model
        logic [7:0] rise;
        logic [7:0] elig;
        int         w;
        exp_t       e;
        ent_t       s;
        if (reset) begin
            m_pend  = '0;
            m_isr   = '0;
            m_gie   = 1'b0;
            m_err   = 1'b0;
            m_phase = 0;
            m_cyc   = 0;
            m_stk.delete();
            exp_q.delete();
            samp = '{8'h00, 8'h00, 8'h00, 8'h00};
        end else begin
            m_cyc++;
            samp.push_front(i_irq_in);
            rise = samp[2] & ~samp[3];
            void'(samp.pop_back());
            elig = m_pend & i_irq_mask;
            w = -1;
            for (int i = NIRQ - 1; i >= 0; i--) if (elig[i]) w = i;
            if (m_phase == 0) begin
                if (i_reti) begin
                    if (m_stk.size() == 0) m_err = 1'b1;
                    else begin
                        s = m_stk.pop_back();
                        e.pc = s.pc; e.ack = '0; e.zl = 1'b1; e.zr = s.z; e.cyc = m_cyc;
                        exp_q.push_back(e);
                        m_phase = 2;
                        m_retid = s.id;
                    end
                end else if (m_gie && w >= 0 && (m_isr & 8'((1 << (w + 1)) - 1)) == 8'h00) begin
                    if (m_stk.size() == DEPTH) m_err = 1'b1;
                    else begin
                        s.z = i_zflag; s.pc = i_pc_next; s.id = w;
                        m_stk.push_back(s);
                        e.pc  = 10'((int'(VEC_BASE) + (w << VEC_SHIFT)) % 1024);
                        e.ack = 8'(1 << w); e.zl = 1'b0; e.zr = 1'b0; e.cyc = m_cyc;
                        exp_q.push_back(e);
                        m_pend[w] = 1'b0;
                        m_isr[w]  = 1'b1;
                        m_phase   = 1;
                    end
                end
            end else begin
                if (i_reti) m_err = 1'b1;
                if (m_phase == 2) m_isr[m_retid] = 1'b0;
                m_phase = 0;
            end
            m_pend = m_pend | rise;
            if (i_di) m_gie = 1'b0;
            else if (i_ei) m_gie = 1'b1;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < m_cyc) begin
                chk("missed_take", 1'b0, 32'(o_take), 32'(exp_q[0].pc));
                void'(exp_q.pop_front());
            end
            if (o_take) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_take", 1'b0, 32'(o_irq_pc), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("take_cycle", e.cyc == m_cyc, 32'(m_cyc), 32'(e.cyc));
                    chk("irq_pc", o_irq_pc == e.pc, 32'(o_irq_pc), 32'(e.pc));
                    chk("ack", o_ack == e.ack, 32'(o_ack), 32'(e.ack));
                    chk("z_load", o_z_load == e.zl, 32'(o_z_load), 32'(e.zl));
                    if (e.zl) chk("z_restore", o_z_restore == e.zr, 32'(o_z_restore), 32'(e.zr));
                end
            end else begin
                chk("quiet_outs", o_irq_pc == '0 && o_ack == '0 && !o_z_load,
                    {13'h0, o_irq_pc, o_ack, o_z_load}, 32'h0);
            end
            chk("err", o_err == m_err, 32'(o_err), 32'(m_err));
            chk("in_service", o_in_service == m_isr, 32'(o_in_service), 32'(m_isr));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic strobe(input int which);
        if (which == 0) i_ei = 1'b1;
        else if (which == 1) i_di = 1'b1;
        else i_reti = 1'b1;
        @(negedge clk);
        i_ei = 1'b0;
        i_di = 1'b0;
        i_reti = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        chk(name, {o_take, o_irq_pc, o_ack, o_z_load, o_z_restore, o_in_service, o_err} == '0,
            {3'h0, o_take, o_irq_pc, o_ack, o_z_load, o_z_restore, o_err}, 32'h0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        cyc(2);
        #1 check_all_zero("reset_outs");
        @(negedge clk);
        reset = 1'b0;
        cyc(2);

        // Single interrupt and return with zero-flag restore.
        i_pc_next = 10'h055; i_zflag = 1'b1;
        strobe(0);
        i_irq_in[2] = 1'b1;
        cyc(8);
        i_pc_next = 10'h123; i_zflag = 1'b0;
        strobe(2);
        cyc(4);

        // Nesting: 0 preempts 2, 3 waits for both to return.
        i_irq_in = '0; cyc(4);
        i_pc_next = 10'h0AA; i_irq_in[2] = 1'b1; cyc(8);
        i_pc_next = 10'h0BB; i_irq_in[3] = 1'b1; i_irq_in[0] = 1'b1; cyc(8);
        strobe(2); cyc(5);
        strobe(2); cyc(8);
        strobe(2); cyc(4);

        // Pending captured with gie clear, serviced after ei.
        i_irq_in = '0; strobe(1); cyc(4);
        i_irq_in[1] = 1'b1; cyc(8);
        strobe(0); cyc(4);
        strobe(2); cyc(4);

        // Masked source keeps its pending bit.
        i_irq_in = '0; i_irq_mask = 8'hFE; cyc(4);
        i_irq_in[0] = 1'b1; cyc(8);
        i_irq_mask = 8'hFF; cyc(4);
        strobe(2); cyc(4);

        // Fill the stack, then overflow with a higher-priority request.
        i_irq_in = '0; cyc(4);
        for (int s = 7; s >= 4; s--) begin
            i_pc_next = 10'(s * 3 + 1); i_zflag = s[0];
            i_irq_in[s] = 1'b1; cyc(8);
        end
        i_irq_in[0] = 1'b1; cyc(8);
        strobe(2); cyc(6);
        for (int r = 0; r < 5; r++) begin strobe(2); cyc(4); end

        // reti with empty stack after a clean reset.
        i_irq_in = '0; do_reset(); cyc(4);
        strobe(2); cyc(3);

        // reti colliding with a freshly eligible request, then reset mid-VECTOR.
        do_reset(); strobe(0);
        i_irq_in[2] = 1'b1; cyc(8);
        i_irq_in[1] = 1'b1; cyc(3);
        strobe(2); cyc(6);
        strobe(2); cyc(4);
        i_irq_in[0] = 1'b1;
        k = 0;
        @(posedge clk); #1;
        while (!o_take && k < 20) begin @(posedge clk); #1; k++; end
        chk("vector_before_reset", o_take == 1'b1, 32'(o_take), 32'h1);
        reset = 1'b1;
        #1 check_all_zero("reset_mid_vector");
        @(negedge clk);
        i_irq_in = '0;
        reset = 1'b0;
        cyc(4);

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            if (n == 400) begin i_irq_in = '0; do_reset(); end
            for (int b = 0; b < NIRQ; b++) if ($urandom_range(15) == 0) i_irq_in[b] = ~i_irq_in[b];
            if ($urandom_range(31) == 0) i_irq_mask = 8'($urandom);
            i_ei      = ($urandom_range(7) == 0);
            i_di      = ($urandom_range(23) == 0);
            i_reti    = ($urandom_range(9) == 0);
            i_pc_next = 10'($urandom);
            i_zflag   = 1'($urandom);
            @(negedge clk);
        end
        i_ei = 1'b0; i_di = 1'b0; i_reti = 1'b0; i_irq_in = '0;
        cyc(10);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
